// File: rtl/mem_access_pkg.sv
// Shared encodings for mem_access: op codes, FSM states, access sizes, strobes and the reset PC.
package mem_access_pkg;

   typedef enum logic [3:0] {
      MemNone = 4'd0,
      MemLb   = 4'd1,
      MemLh   = 4'd2,
      MemLw   = 4'd3,
      MemLd   = 4'd4,
      MemLbu  = 4'd5,
      MemLhu  = 4'd6,
      MemLwu  = 4'd7,
      MemSb   = 4'd8,
      MemSh   = 4'd9,
      MemSw   = 4'd10,
      MemSd   = 4'd11
   } mem_op_e;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StBusy = 2'd1,
      StDone = 2'd2
   } mem_state_e;

   typedef enum logic [1:0] {
      SizeB = 2'd0,
      SizeH = 2'd1,
      SizeW = 2'd2,
      SizeD = 2'd3
   } mem_size_e;

   localparam logic [7:0]  StrbB     = 8'h01;
   localparam logic [7:0]  StrbH     = 8'h03;
   localparam logic [7:0]  StrbW     = 8'h0F;
   localparam logic [7:0]  StrbD     = 8'hFF;
   localparam logic [63:0] InvalidPc = 64'hFFFF_FFFF_DEAD_0000;

   function automatic logic op_is_load(logic [3:0] op);
      return (op >= MemLb) && (op <= MemLwu);
   endfunction

   function automatic logic op_is_store(logic [3:0] op);
      return (op >= MemSb) && (op <= MemSd);
   endfunction

   function automatic logic op_unsigned(logic [3:0] op);
      return (op == MemLbu) || (op == MemLhu) || (op == MemLwu) || (op == MemLd);
   endfunction

   function automatic mem_size_e op_size(logic [3:0] op);
      case (op)
         MemLb, MemLbu, MemSb: return SizeB;
         MemLh, MemLhu, MemSh: return SizeH;
         MemLw, MemLwu, MemSw: return SizeW;
         default:              return SizeD;
      endcase
   endfunction

   function automatic logic [7:0] size_strb(mem_size_e size);
      case (size)
         SizeB:   return StrbB;
         SizeH:   return StrbH;
         SizeW:   return StrbW;
         default: return StrbD;
      endcase
   endfunction

   // Byte-index mask used to replicate store data across lanes.
   function automatic logic [2:0] size_mask(mem_size_e size);
      case (size)
         SizeB:   return 3'b000;
         SizeH:   return 3'b001;
         SizeW:   return 3'b011;
         default: return 3'b111;
      endcase
   endfunction

   function automatic logic is_misaligned(mem_size_e size, logic [2:0] off);
      return |(off & size_mask(size));
   endfunction

endpackage

// File: rtl/mem_access_if.sv
// Data bus between mem_access (master) and the data memory (slave).
interface mem_access_if #(
   parameter int unsigned XLEN      = 64,
   parameter int unsigned BUS_LANES = 8
);
   logic                 dbus_req_o;
   logic                 dbus_we_o;
   logic [XLEN-1:0]      dbus_addr_o;
   logic [XLEN-1:0]      dbus_wdata_o;
   logic [BUS_LANES-1:0] dbus_wstrb_o;
   logic                 dbus_ack_i;
   logic [XLEN-1:0]      dbus_rdata_i;

   modport master (
      output dbus_req_o, dbus_we_o, dbus_addr_o, dbus_wdata_o, dbus_wstrb_o,
      input  dbus_ack_i, dbus_rdata_i
   );

   modport slave (
      input  dbus_req_o, dbus_we_o, dbus_addr_o, dbus_wdata_o, dbus_wstrb_o,
      output dbus_ack_i, dbus_rdata_i
   );
endinterface

// File: rtl/mem_load_align.sv
// Combinational load aligner: shift bus data down by the byte offset, truncate to size, extend.
module mem_load_align
   import mem_access_pkg::*;
#(
   parameter int unsigned XLEN = 64
) (
   input  logic [XLEN-1:0] rdata,
   input  logic [2:0]      offset,
   input  mem_size_e       size,
   input  logic            is_unsigned,
   output logic [XLEN-1:0] data
);

   logic [XLEN-1:0] shifted;
   logic            sign;

   always_comb begin
      shifted = rdata >> {offset, 3'b000};
      sign    = 1'b0;
      data    = shifted;
      unique case (size)
         SizeB: begin
            sign = shifted[7] & ~is_unsigned;
            data = {{(XLEN-8){sign}}, shifted[7:0]};
         end
         SizeH: begin
            sign = shifted[15] & ~is_unsigned;
            data = {{(XLEN-16){sign}}, shifted[15:0]};
         end
         SizeW: begin
            sign = shifted[31] & ~is_unsigned;
            data = {{(XLEN-32){sign}}, shifted[31:0]};
         end
         SizeD: data = shifted;
      endcase
   end

endmodule

// File: rtl/mem_access.sv
// MEM stage: stalls the pipeline around one data-bus transaction per load/store.
// Optional macro MEM_MISALIGN_CHECK_EN traps non size-aligned H/W/D accesses instead of issuing them.
module mem_access
   import mem_access_pkg::*;
#(
   parameter int unsigned XLEN      = 64,
   parameter int unsigned BUS_LANES = XLEN / 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              valid_i,
   input  logic [3:0]        mem_op_i,
   input  logic [XLEN-1:0]   mem_addr_i,
   input  logic [XLEN-1:0]   store_data_i,
   input  logic [4:0]        rd_addr_i,
   input  logic              wreg_i,
   input  logic [XLEN-1:0]   wdata_i,
   input  logic [XLEN-1:0]   pc_i,
   output logic [4:0]        rd_addr_o,
   output logic              wreg_o,
   output logic [XLEN-1:0]   wdata_o,
   output logic [XLEN-1:0]   mem_pc_o,
   output logic              stall_req_o,
   output logic              misalign_o,
   mem_access_if.master      dbus
);

   mem_state_e           state_q, state_d;
   logic [3:0]           op_q;
   logic [XLEN-1:0]      addr_q, sdata_q, wdata_q, pc_q, load_q;
   logic [4:0]           rd_q;
   logic                 wreg_q;

   logic                 is_mem, misalign, start, capture;
   logic [XLEN-1:0]      load_aligned, bus_wdata;
   logic [BUS_LANES-1:0] bus_strb;
   logic [2:0]           lane_mask;

   assign is_mem = valid_i & (op_is_load(mem_op_i) | op_is_store(mem_op_i));
`ifdef MEM_MISALIGN_CHECK_EN
   assign misalign = is_mem & is_misaligned(op_size(mem_op_i), mem_addr_i[2:0]);
`else
   assign misalign = 1'b0;
`endif
   assign start   = (state_q == StIdle) & is_mem & ~misalign;
   assign capture = (state_q == StBusy) & dbus.dbus_ack_i;

   mem_load_align #(
      .XLEN (XLEN)
   ) u_load_align (
      .rdata       (dbus.dbus_rdata_i),
      .offset      (addr_q[2:0]),
      .size        (op_size(op_q)),
      .is_unsigned (op_unsigned(op_q)),
      .data        (load_aligned)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= StIdle;
         op_q    <= 4'd0;
         addr_q  <= '0;
         sdata_q <= '0;
         wdata_q <= '0;
         rd_q    <= 5'd0;
         wreg_q  <= 1'b0;
         pc_q    <= XLEN'(InvalidPc);
         load_q  <= '0;
      end else begin
         state_q <= state_d;
         if (start) begin
            op_q    <= mem_op_i;
            addr_q  <= mem_addr_i;
            sdata_q <= store_data_i;
            wdata_q <= wdata_i;
            rd_q    <= rd_addr_i;
            wreg_q  <= wreg_i;
            pc_q    <= pc_i;
         end
         if (capture) begin
            load_q <= load_aligned;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (start) state_d = StBusy;
         StBusy:  if (dbus.dbus_ack_i) state_d = StDone;
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Store data is replicated so every lane carries the right bytes regardless of offset.
   always_comb begin
      lane_mask = size_mask(op_size(op_q));
      bus_strb  = op_is_store(op_q) ?
                  (BUS_LANES'(size_strb(op_size(op_q))) << addr_q[2:0]) : '0;
      bus_wdata = '0;
      for (int i = 0; i < BUS_LANES; i++) begin
         bus_wdata[8*i +: 8] = sdata_q[8*int'(3'(i) & lane_mask) +: 8];
      end
   end

   always_comb begin
      rd_addr_o         = rd_addr_i;
      wreg_o            = wreg_i;
      wdata_o           = wdata_i;
      mem_pc_o          = pc_i;
      stall_req_o       = 1'b0;
      misalign_o        = 1'b0;
      dbus.dbus_req_o   = 1'b0;
      dbus.dbus_we_o    = 1'b0;
      dbus.dbus_addr_o  = '0;
      dbus.dbus_wdata_o = '0;
      dbus.dbus_wstrb_o = '0;
      unique case (state_q)
         StIdle: begin
            if (misalign) begin
               wreg_o     = 1'b0;
               misalign_o = 1'b1;
            end else if (start) begin
               wreg_o      = 1'b0;
               stall_req_o = 1'b1;
            end
         end
         StBusy: begin
            rd_addr_o         = rd_q;
            wreg_o            = 1'b0;
            wdata_o           = wdata_q;
            mem_pc_o          = pc_q;
            stall_req_o       = 1'b1;
            dbus.dbus_req_o   = 1'b1;
            dbus.dbus_we_o    = op_is_store(op_q);
            dbus.dbus_addr_o  = {addr_q[XLEN-1:3], 3'b000};
            dbus.dbus_wdata_o = bus_wdata;
            dbus.dbus_wstrb_o = bus_strb;
         end
         StDone: begin
            rd_addr_o = rd_q;
            wreg_o    = op_is_load(op_q) & wreg_q;
            wdata_o   = op_is_load(op_q) ? load_q : wdata_q;
            mem_pc_o  = pc_q;
         end
         default: ;
      endcase
      if (!rst) begin
         rd_addr_o         = 5'd0;
         wreg_o            = 1'b0;
         wdata_o           = '0;
         mem_pc_o          = XLEN'(InvalidPc);
         stall_req_o       = 1'b0;
         misalign_o        = 1'b0;
         dbus.dbus_req_o   = 1'b0;
         dbus.dbus_we_o    = 1'b0;
         dbus.dbus_addr_o  = '0;
         dbus.dbus_wdata_o = '0;
         dbus.dbus_wstrb_o = '0;
      end
   end

endmodule
